// File: rtl/data_mem_store_unit.sv
// rtl/data_mem_store_unit.sv - store sequencer: SW direct write, SH/SB read-modify-write; optional DATA_MEM_MISALIGN_CHECK_EN
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef OPCODE_STORE
`define OPCODE_STORE 7'b0100011
`endif
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif
`ifndef FUNCT3_SB
`define FUNCT3_SB 3'b000
`endif
`ifndef FUNCT3_SH
`define FUNCT3_SH 3'b001
`endif
`ifndef FUNCT3_SW
`define FUNCT3_SW 3'b010
`endif

module data_mem_store_unit #(
  parameter int N = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [`OPCODE_WIDTH-1:0] opcode,
  input  logic [`FUNCT3_WIDTH-1:0] funct3,
  input  logic [N-1:0]             addr,
  input  logic [N-1:0]             wdata,
  output logic [N-1:0]             mem_addr,
  output logic                     mem_re,
  input  logic [N-1:0]             mem_rdata,
  output logic                     mem_we,
  output logic [N-1:0]             mem_wdata,
  output logic                     done
`ifdef DATA_MEM_MISALIGN_CHECK_EN
  ,
  output logic                     misaligned
`endif
);

  typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;

  state_t                   state;
  logic [`FUNCT3_WIDTH-1:0] funct3_q;
  logic [15:0]              wdata_q;
  logic                     accept;
  logic                     misalign_req;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready && (opcode == `OPCODE_STORE);

`ifdef DATA_MEM_MISALIGN_CHECK_EN
  // SB is always aligned; SH needs an even address, SW a word-aligned one.
  assign misalign_req = ((funct3 == `FUNCT3_SW) && (addr[1:0] != 2'b00)) ||
                        ((funct3 == `FUNCT3_SH) && addr[0]);
`else
  // Without the check the low address bits only disappear into word alignment.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];
  assign misalign_req     = 1'b0;
`endif

  // Store sequencer: every output is registered; strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      funct3_q  <= '0;
      wdata_q   <= '0;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
      misaligned <= 1'b0;
`endif
    end else begin
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      done   <= 1'b0;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
      misaligned <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            funct3_q <= funct3;
            wdata_q  <= wdata[15:0];
            if (misalign_req) begin
              // Rejected store retires immediately without touching memory.
              done <= 1'b1;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
              misaligned <= 1'b1;
`endif
            end else begin
              case (funct3)
                `FUNCT3_SW: begin
                  mem_addr  <= {addr[N-1:2], 2'b00};
                  mem_wdata <= wdata;
                  mem_we    <= 1'b1;
                  done      <= 1'b1;
                  state     <= WRITE;
                end
                `FUNCT3_SH, `FUNCT3_SB: begin
                  mem_addr <= {addr[N-1:2], 2'b00};
                  mem_re   <= 1'b1;
                  state    <= READ;
                end
                default: begin
                  // Unsupported width: drop it but still retire so the pipe advances.
                  done <= 1'b1;
                end
              endcase
            end
          end
        end
        READ: begin
          state <= MERGE;
        end
        MERGE: begin
          // New bytes land in the upper lanes, matching the load path's extraction.
          if (funct3_q == `FUNCT3_SH) begin
            mem_wdata <= {wdata_q[15:0], mem_rdata[N-17:0]};
          end else begin
            mem_wdata <= {wdata_q[7:0], mem_rdata[N-9:0]};
          end
          mem_we <= 1'b1;
          done   <= 1'b1;
          state  <= WRITE;
        end
        WRITE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_store_unit.sv
// tb/tb_data_mem_store_unit.sv - randomized self-checking bench for data_mem_store_unit
module tb_data_mem_store_unit;

  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [2:0] F_SB     = 3'b000;
  localparam logic [2:0] F_SH     = 3'b001;
  localparam logic [2:0] F_SW     = 3'b010;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        done;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  int checks = 0;
  int errors = 0;
  int overlap_count = 0;
  int we_count = 0;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  always #5 clk = ~clk;

  data_mem_store_unit #(.N(32)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .opcode(opcode),
    .funct3(funct3),
    .addr(addr),
    .wdata(wdata),
    .mem_addr(mem_addr),
    .mem_re(mem_re),
    .mem_rdata(mem_rdata),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .done(done)
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    ,
    .misaligned(misaligned)
`endif
  );

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] x;
    x = 32'(i);
    if (i == 'h41 || i == 'h42) return 32'h11223344;
    return (x * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  // Word-addressed memory without byte enables; read data appears one cycle after mem_re.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_rdata <= '0;
    end else begin
      if (mem_re) mem_rdata <= mem[mem_addr[9:2]];
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (mem_re && mem_we) overlap_count++;
    if (mem_we) we_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    opcode    = op;
    funct3    = f;
    addr      = a;
    wdata     = d;
  endtask

  task automatic reset_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          exp_lat;
    int          we_snap;
    logic        wr;
    logic [2:0]  f3;
    logic [7:0]  widx;
    logic [1:0]  low;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] old;
    logic [31:0] exp_word;

    rst = 1'b1;
    drive(1'b0, 7'd0, 3'd0, 32'd0, 32'd0);
    reset_ref();
    tick();
    tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_done", done, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_req_ready", req_ready, 1);
      check("idle_mem_re", mem_re, 0);
      check("idle_mem_we", mem_we, 0);
      check("idle_done", done, 0);
    end

    // SW: single write one cycle after acceptance
    drive(1'b1, OP_STORE, F_SW, 32'h100, 32'hDEADBEEF);
    tick();
    drive(1'b0, OP_STORE, F_SW, 32'h0, 32'h0);
    check("sw_we", mem_we, 1);
    check("sw_addr", mem_addr, 32'h100);
    check("sw_wdata", mem_wdata, 32'hDEADBEEF);
    check("sw_done", done, 1);
    check("sw_re", mem_re, 0);
    check("sw_ready_busy", req_ready, 0);
    tick();
    check("sw_we_end", mem_we, 0);
    check("sw_done_end", done, 0);
    check("sw_ready_back", req_ready, 1);
    ref_mem['h40] = 32'hDEADBEEF;

    // SH: read at T+1, merge, write at T+3
    drive(1'b1, OP_STORE, F_SH, 32'h104, 32'h0000ABCD);
    tick();
    drive(1'b0, OP_LOAD, 3'd0, 32'h0, 32'h0);
    check("sh_t1_re", mem_re, 1);
    check("sh_t1_addr", mem_addr, 32'h104);
    check("sh_t1_we", mem_we, 0);
    check("sh_t1_ready", req_ready, 0);
    tick();
    check("sh_t2_re", mem_re, 0);
    check("sh_t2_we", mem_we, 0);
    check("sh_t2_ready", req_ready, 0);
    check("sh_t2_done", done, 0);
    tick();
    check("sh_t3_we", mem_we, 1);
    check("sh_t3_wdata", mem_wdata, 32'hABCD3344);
    check("sh_t3_addr", mem_addr, 32'h104);
    check("sh_t3_done", done, 1);
    check("sh_t3_ready", req_ready, 0);
    tick();
    check("sh_t4_ready", req_ready, 1);
    ref_mem['h41] = 32'hABCD3344;

    // SB followed by a SW held on req_valid until accepted
    drive(1'b1, OP_STORE, F_SB, 32'h108, 32'h000000EE);
    tick();
    drive(1'b1, OP_STORE, F_SW, 32'h10C, 32'h12345678);
    check("sb_t1_re", mem_re, 1);
    tick();
    check("sb_t2_ready", req_ready, 0);
    tick();
    check("sb_t3_we", mem_we, 1);
    check("sb_t3_wdata", mem_wdata, 32'hEE223344);
    check("sb_t3_done", done, 1);
    tick();
    check("b2b_t4_ready", req_ready, 1);
    check("b2b_t4_we", mem_we, 0);
    tick();
    drive(1'b0, OP_STORE, F_SW, 32'h0, 32'h0);
    check("b2b_t5_we", mem_we, 1);
    check("b2b_t5_addr", mem_addr, 32'h10C);
    check("b2b_t5_wdata", mem_wdata, 32'h12345678);
    tick();
    ref_mem['h42] = 32'hEE223344;
    ref_mem['h43] = 32'h12345678;

    // Non-store opcode is ignored entirely
    drive(1'b1, OP_LOAD, F_SW, 32'h110, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("load_done", done, 0);
      check("load_we", mem_we, 0);
      check("load_re", mem_re, 0);
      check("load_ready", req_ready, 1);
    end

    // Unsupported funct3: retire at T+1 without memory access
    drive(1'b1, OP_STORE, 3'b011, 32'h110, 32'hCAFEF00D);
    tick();
    drive(1'b0, OP_LOAD, 3'd0, 32'h0, 32'h0);
    check("f3bad_done", done, 1);
    check("f3bad_we", mem_we, 0);
    check("f3bad_re", mem_re, 0);
    tick();
    check("f3bad_done_end", done, 0);
    check("f3bad_we_end", mem_we, 0);

    // Reset during MERGE abandons the pending write
    drive(1'b1, OP_STORE, F_SH, 32'h104, 32'h00005555);
    tick();
    drive(1'b0, OP_LOAD, 3'd0, 32'h0, 32'h0);
    we_snap = we_count;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_ref();
    check("rstmid_we", mem_we, 0);
    check("rstmid_done", done, 0);
    check("rstmid_ready", req_ready, 1);
    tick();
    tick();
    check("rstmid_we_count", 32'(we_count - we_snap), 0);

`ifdef DATA_MEM_MISALIGN_CHECK_EN
    drive(1'b1, OP_STORE, F_SW, 32'h102, 32'h87654321);
    tick();
    drive(1'b0, OP_LOAD, 3'd0, 32'h0, 32'h0);
    check("mis_sw_flag", misaligned, 1);
    check("mis_sw_done", done, 1);
    check("mis_sw_we", mem_we, 0);
    check("mis_sw_re", mem_re, 0);
    tick();
    check("mis_sw_flag_end", misaligned, 0);
    drive(1'b1, OP_STORE, F_SH, 32'h105, 32'h00001234);
    tick();
    drive(1'b0, OP_LOAD, 3'd0, 32'h0, 32'h0);
    check("mis_sh_flag", misaligned, 1);
    check("mis_sh_re", mem_re, 0);
    tick();
`endif

    // Randomized stores against an arithmetic model of the target word
    for (int it = 0; it < 60; it++) begin
      int sel;
      sel  = int'($urandom_range(0, 9));
      widx = 8'h80 + 8'($urandom_range(0, 15));
      low  = 2'($urandom_range(0, 3));
      d    = $urandom;
      if (sel < 4)      f3 = F_SW;
      else if (sel < 7) f3 = F_SH;
      else if (sel < 9) f3 = F_SB;
      else              f3 = 3'($urandom_range(3, 7));
`ifdef DATA_MEM_MISALIGN_CHECK_EN
      if (f3 == F_SW) low = 2'b00;
      if (f3 == F_SH) low[0] = 1'b0;
`endif
      a   = {22'd0, widx, low};
      old = ref_mem[widx];
      case (f3)
        F_SW: begin exp_word = d; exp_lat = 1; wr = 1'b1; end
        F_SH: begin exp_word = (old & 32'h0000FFFF) | ((d & 32'h0000FFFF) << 16); exp_lat = 3; wr = 1'b1; end
        F_SB: begin exp_word = (old & 32'h00FFFFFF) | ((d & 32'h000000FF) << 24); exp_lat = 3; wr = 1'b1; end
        default: begin exp_word = old; exp_lat = 1; wr = 1'b0; end
      endcase
      drive(1'b1, OP_STORE, f3, a, d);
      lat = 0;
      do begin
        tick();
        drive(1'b0, 7'($urandom), 3'($urandom), $urandom, $urandom);
        lat++;
      end while (!done && lat < 8);
      check("rand_latency", 32'(lat), 32'(exp_lat));
      check("rand_we", mem_we, wr);
      if (wr) begin
        check("rand_wdata", mem_wdata, exp_word);
        check("rand_addr", mem_addr, {a[31:2], 2'b00});
      end
      ref_mem[widx] = exp_word;
      tick();
      check("rand_ready", req_ready, 1);
    end

    check("re_we_exclusive", 32'(overlap_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
